ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered bytes; power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data  input  1  raw asynchronous PS/2 data line.
REQ-007 SHALL have port rd_en  input  1  consumer pop request; honoured only while ready=1.
REQ-008 SHALL have port data  output  8  oldest buffered scan byte, first-word fall-through.
REQ-009 SHALL have port ready  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through a 2-flop synchronizer, plus one history flop on ps2_clk.
REQ-013 SHALL flag a falling edge in the cycle where the history flop is 1 and synchronized ps2_clk is 0.
REQ-014 SHALL sample synchronized ps2_data on each falling edge into a 10-bit shift buffer, with bit counter 0..10.
REQ-015 SHALL treat the 11th falling edge (counter=10) as frame end and return the counter to 0 in the same cycle.
REQ-016 SHALL accept a frame only if start=0, stop=1 and data[7:0] XOR parity = 1 (odd parity); data is received LSB first.
REQ-017 SHALL, on a rejected frame, pulse frame_err for exactly one cycle, discard the frame and write nothing.
REQ-018 SHALL write an accepted byte at the end of the frame-end cycle N; ready=1 and data valid from cycle N+1.
REQ-019 SHALL, when rd_en=1 and ready=1, advance the read pointer so the next byte, or empty, is visible the following cycle.
REQ-020 SHALL ignore rd_en while ready=0.
REQ-021 SHALL, on an accepted byte with the FIFO full and no simultaneous pop, drop the byte and set overflow.
REQ-022 SHALL, on a simultaneous push and pop when full, perform both with occupancy unchanged and no overflow.
REQ-023 SHALL wrap read and write pointers modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-024 SHALL drive data to 8'h00 whenever ready=0.
REQ-025 SHALL, while counter is not 0, count idle cycles; on reaching TIMEOUT_CYC, clear counter and shift buffer silently, with no frame_err.
REQ-026 SHALL clear the idle counter on every falling edge and whenever the bit counter is 0.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, clear pointers, occupancy, bit counter, shift buffer, idle counter, overflow and frame_err.
REQ-028 SHALL preset synchronizer and history flops to 1 (idle line) on reset.
REQ-029 SHALL hold outputs at ready=0, data=8'h00, overflow=0 and frame_err=0 during reset and in the first cycle after it.
REQ-030 SHALL, when reset hits mid-frame, discard the partial frame and clear all buffered bytes.
REQ-031 SHALL clear overflow only by rst.

Structure
REQ-032 SHALL keep PS2_FRAME_BITS=11, the FIFO_DEPTH default and the TIMEOUT_CYC default in shared package ps2_pkg.
REQ-033 SHALL implement storage in one sub-module, ps2_byte_fifo, a synchronous FIFO with push, pop, full and empty; framing logic stays in ps2_rx_fifo.

Verification
REQ-034 SHALL cover: frame 0x1C (parity 0) -> ready=1, data=0x1C; one rd_en pulse -> ready=0, data=0x00.
REQ-035 SHALL cover: frames 0xF0 then 0x1C with no reads -> data=0xF0; pop -> 0x1C; pop -> ready=0.
REQ-036 SHALL cover: frame 0x1C with parity=1 -> single-cycle frame_err pulse, ready stays 0.
REQ-037 SHALL cover: 9 frames 0x01..0x09 with no reads, FIFO_DEPTH=8 -> overflow=1; reads return 0x01..0x08 in order, then ready=0.
REQ-038 SHALL cover: 5 bits then idle greater than TIMEOUT_CYC (TIMEOUT_CYC=100 in bench), then full frame 0x32 -> only 0x32 received, frame_err never pulses.
REQ-039 SHALL cover: rst asserted after 6 bits of a frame -> ready=0, overflow=0; next complete frame 0x1C -> data=0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame constants, parameter defaults and frame check helper.
// Rev 1.0
`default_nettype none

package ps2_pkg;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_FIFO_DEPTH  = 8;
  localparam int PS2_TIMEOUT_CYC = 50000;

  // Frame fields after ten shifts: [0]=start, [8:1]=data (LSB first), [9]=parity.
  function automatic logic frame_ok(input logic [9:0] sh, input logic stop_bit);
    return (sh[0] == 1'b0) && stop_bit && (^sh[9:1]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous first-word-fall-through FIFO for received scan bytes.
// Rev 1.0
`default_nettype none

module ps2_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a scan-byte FIFO.
// Rev 1.0
`default_nettype none

module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = PS2_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic              clk_s1, clk_s2, clk_hist;
  logic              dat_s1, dat_s2;
  logic              fall;
  logic [3:0]        bit_cnt;
  logic [9:0]        shift_buf;
  logic [IDLE_W-1:0] idle_cnt;
  logic              frame_end;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  // Synchronizers preset high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall      = clk_hist & ~clk_s2;
  assign frame_end = fall && (bit_cnt == 4'(PS2_FRAME_BITS - 1));
  assign accept    = frame_ok(shift_buf, dat_s2);
  assign push      = frame_end & accept;
  assign pop       = rd_en & ready;
  assign ready     = ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_buf <= '0;
      idle_cnt  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_end & ~accept;
      if (push && full && !pop) overflow <= 1'b1;

      if (fall) begin
        idle_cnt <= '0;
        if (frame_end) begin
          bit_cnt   <= '0;
          shift_buf <= '0;
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          shift_buf <= {dat_s2, shift_buf[9:1]};
        end
      end else if (bit_cnt == '0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
        // Stalled partial frame: drop it quietly, not a framing error.
        idle_cnt  <= '0;
        bit_cnt   <= '0;
        shift_buf <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_buf[8:1]),
    .pop   (pop),
    .rdata (data),
    .full  (full),
    .empty (empty)
  );

endmodule

`default_nettype wire
